// File: rtl/mac_job_sequencer.sv
// Issues the operand beats of a K-step dot-product job to one compute unit and returns the final sum.
// Optional SEQ_PERF_CNT_EN adds saturating busy/stall cycle counters.
module mac_job_sequencer #(
  parameter int OUT_BIT  = 32,
  parameter int INWID    = 4,
  parameter int MAC_O    = 4,
  parameter int UNIT_LAT = 1,
  parameter int KW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  input  logic [1:0]           cfg_ctrl,
  input  logic [OUT_BIT-1:0]   cfg_acc,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INWID*4-1:0]   in_wgt [MAC_O],
  input  logic [INWID*4-1:0]   in_act [MAC_O],
  output logic [1:0]           u_ctrl,
  output logic [INWID*4-1:0]   u_wgt [MAC_O],
  output logic [INWID*4-1:0]   u_act [MAC_O],
  output logic [OUT_BIT-1:0]   u_acc,
  input  logic [OUT_BIT-1:0]   u_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_BIT-1:0]   res_data
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall
`endif
);

  localparam int WCW = (UNIT_LAT > 0) ? $clog2(UNIT_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        beats_q;
  logic [WCW-1:0]       wcnt_q;
  logic [OUT_BIT-1:0]   psum_q;

  logic load_cfg, take_beat, close_beat, finish;

  always_comb begin
    state_d    = state_q;
    load_cfg   = 1'b0;
    take_beat  = 1'b0;
    close_beat = 1'b0;
    finish     = 1'b0;
    busy       = (state_q != S_IDLE);
    in_ready   = (state_q == S_FEED);
    res_valid  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          state_d  = (cfg_k == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (in_valid) begin
          take_beat = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // The unit output is valid in the cycle the wait count reaches zero.
        if (wcnt_q == '0) begin
          close_beat = 1'b1;
          state_d    = (beats_q < k_q) ? S_FEED : S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      beats_q  <= '0;
      wcnt_q   <= '0;
      psum_q   <= '0;
      u_ctrl   <= '0;
      u_acc    <= '0;
      res_data <= '0;
      for (int unsigned i = 0; i < MAC_O; i++) begin
        u_wgt[i] <= '0;
        u_act[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        k_q     <= cfg_k;
        u_ctrl  <= cfg_ctrl;
        psum_q  <= cfg_acc;
        beats_q <= '0;
        if (cfg_k == '0)
          res_data <= cfg_acc;
      end
      if (take_beat) begin
        for (int unsigned i = 0; i < MAC_O; i++) begin
          u_wgt[i] <= in_wgt[i];
          u_act[i] <= in_act[i];
        end
        u_acc   <= psum_q;
        beats_q <= beats_q + 1'b1;
        wcnt_q  <= WCW'(UNIT_LAT);
      end
      if (state_q == S_WAIT && wcnt_q != '0)
        wcnt_q <= wcnt_q - 1'b1;
      if (close_beat) begin
        psum_q <= u_out;
        if (state_d == S_DONE)
          res_data <= u_out;
      end
      if (finish) begin
        psum_q  <= '0;
        beats_q <= '0;
        wcnt_q  <= '0;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic stall;
  assign stall = (state_q == S_FEED && !in_valid) || (state_q == S_DONE && !res_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && perf_busy != '1)
        perf_busy <= perf_busy + 1'b1;
      if (stall && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural MAC unit stub and a result scoreboard.
`timescale 1ns/1ps
module tb_mac_job_sequencer;
  localparam int OUT_BIT  = 32;
  localparam int INWID    = 4;
  localparam int MAC_O    = 4;
  localparam int UNIT_LAT = 1;
  localparam int KW       = 16;
  localparam int LW       = INWID * 4;

  typedef logic [LW-1:0] lanes_t [MAC_O];

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [KW-1:0]      cfg_k;
  logic [1:0]         cfg_ctrl;
  logic [OUT_BIT-1:0] cfg_acc;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  lanes_t             in_wgt, in_act, u_wgt, u_act;
  logic [1:0]         u_ctrl;
  logic [OUT_BIT-1:0] u_acc, u_out;
  logic               res_valid, res_ready;
  logic [OUT_BIT-1:0] res_data;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]        perf_busy, perf_stall;
`endif

  mac_job_sequencer #(
    .OUT_BIT(OUT_BIT), .INWID(INWID), .MAC_O(MAC_O), .UNIT_LAT(UNIT_LAT), .KW(KW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .cfg_ctrl(cfg_ctrl),
    .cfg_acc(cfg_acc), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_wgt(in_wgt), .in_act(in_act), .u_ctrl(u_ctrl), .u_wgt(u_wgt), .u_act(u_act),
    .u_acc(u_acc), .u_out(u_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
`ifdef SEQ_PERF_CNT_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_BIT-1:0] dot(input lanes_t w, input lanes_t a);
    logic [OUT_BIT-1:0] s;
    s = '0;
    for (int i = 0; i < MAC_O; i++) s += OUT_BIT'(w[i]) * OUT_BIT'(a[i]);
    return s;
  endfunction

  // Unit stub with one register stage (UNIT_LAT = 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) u_out <= '0;
    else       u_out <= u_acc + dot(u_wgt, u_act);
  end

  int cyc = 0;
  int ready_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready) ready_cnt <= ready_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [OUT_BIT-1:0] exp_q [$];
  logic [OUT_BIT-1:0] m_psum;
  int t_start, t_valid;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [KW-1:0] k, input logic [1:0] ctrl, input logic [OUT_BIT-1:0] acc);
    start = 1'b1; cfg_k = k; cfg_ctrl = ctrl; cfg_acc = acc;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    m_psum = acc;
    check1("busy_after_start", busy, 1'b1);
  endtask

  task automatic feed_beat(input lanes_t w, input lanes_t a, input int gap);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("in_ready_wait", in_ready, 1'b1);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check1("in_ready_gap", in_ready, 1'b1);
    end
    in_valid = 1'b1; in_wgt = w; in_act = a;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < MAC_O; i++) begin
      check32("u_wgt_lane", 32'(u_wgt[i]), 32'(w[i]));
      check32("u_act_lane", 32'(u_act[i]), 32'(a[i]));
    end
    check32("u_acc_beat", u_acc, m_psum);
    check1("in_ready_wait_state", in_ready, 1'b0);
    m_psum = m_psum + dot(w, a);
  endtask

  task automatic get_result(input int hold, input bit start_at_hs);
    int n;
    logic [OUT_BIT-1:0] exp;
    res_ready = (hold == 0);
    n = 0;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check1("res_valid_seen", res_valid, 1'b1);
    t_valid = cyc;
    check1("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < hold; i++) begin
      check1("res_valid_hold", res_valid, 1'b1);
      check32("res_data_hold", res_data, exp);
      @(negedge clk);
    end
    res_ready = 1'b1;
    if (start_at_hs) start = 1'b1;
    check1("res_valid_hs", res_valid, 1'b1);
    check32("res_data", res_data, exp);
    @(negedge clk);
    check1("busy_after_hs", busy, 1'b0);
    start = 1'b0;
    check1("res_valid_drop", res_valid, 1'b0);
  endtask

  lanes_t w, a, w2, a2, w3, a3;
  int r0;

  initial begin
    reset = 1'b1; start = 1'b0; cfg_k = '0; cfg_ctrl = '0; cfg_acc = '0;
    in_valid = 1'b0; res_ready = 1'b1;
    in_wgt = '{default: '0}; in_act = '{default: '0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_res_valid", res_valid, 1'b0);
    check32("rst_res_data", res_data, '0);
    check32("rst_u_acc", u_acc, '0);

    // Scenario 1: two beats of 4*(1*2) onto acc 5.
    w = '{16'd1, 16'd1, 16'd1, 16'd1};
    a = '{16'd2, 16'd2, 16'd2, 16'd2};
    exp_q.push_back(32'd5 + dot(w, a) + dot(w, a));
    do_start(16'd2, 2'b00, 32'd5);
    feed_beat(w, a, 0);
    feed_beat(w, a, 0);
    check32("beat2_u_acc", u_acc, 32'd13);
    get_result(0, 1'b1);
    check32("job_latency", 32'(t_valid - t_start), 32'(2 * (UNIT_LAT + 2) + 1));
`ifdef SEQ_PERF_CNT_EN
    check32("perf_busy_s1", perf_busy, 32'(2 * (UNIT_LAT + 2) + 1));
    check32("perf_stall_s1", perf_stall, 32'd0);
`endif

    // Scenario 3: three beats, 5-cycle operand gap, 4-cycle result backpressure.
    w  = '{16'd1, 16'd2, 16'd3, 16'd4};      a  = '{16'd5, 16'd6, 16'd7, 16'd8};
    w2 = '{16'd10, 16'd20, 16'd30, 16'd40};  a2 = '{16'd1, 16'd1, 16'd1, 16'd1};
    w3 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; a3 = '{16'd2, 16'd2, 16'd2, 16'd2};
    exp_q.push_back(32'd100 + 32'd70 + 32'd100 + 32'd524280);
    do_start(16'd3, 2'b11, 32'd100);
    feed_beat(w, a, 0);
    feed_beat(w2, a2, 5);
    feed_beat(w3, a3, 0);
    get_result(4, 1'b0);
`ifdef SEQ_PERF_CNT_EN
    check32("perf_busy_s3", perf_busy, 32'(2 * (UNIT_LAT + 2) + 1 + 3 * (UNIT_LAT + 2) + 1 + 9));
    check32("perf_stall_s3", perf_stall, 32'd9);
`endif

    // Scenario 2: zero-length job returns cfg_acc without touching the operand port.
    r0 = ready_cnt;
    exp_q.push_back(32'h1234);
    do_start(16'd0, 2'b01, 32'h1234);
    get_result(0, 1'b0);
    check32("k0_latency", 32'(t_valid - t_start), 32'd1);
    check32("k0_no_in_ready", 32'(ready_cnt - r0), 32'd0);

    // Scenario 4: async reset in the WAIT of beat 2, then a fresh job.
    do_start(16'd3, 2'b10, 32'd7);
    feed_beat(w, a, 0);
    feed_beat(w2, a2, 0);
    #2 reset = 1'b1;
    #1;
    check1("arst_busy", busy, 1'b0);
    check1("arst_in_ready", in_ready, 1'b0);
    check1("arst_res_valid", res_valid, 1'b0);
    check32("arst_u_acc", u_acc, '0);
    check32("arst_u_wgt0", 32'(u_wgt[0]), '0);
    check32("arst_u_act3", 32'(u_act[3]), '0);
    check32("arst_u_ctrl", 32'(u_ctrl), '0);
    check32("arst_res_data", res_data, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    w = '{16'd3, 16'd3, 16'd3, 16'd3};
    exp_q.push_back(32'd36);
    do_start(16'd1, 2'b00, 32'd0);
    feed_beat(w, w, 0);
    get_result(0, 1'b0);

    // Scenario 5: start and cfg changes during a job are ignored.
    w = '{16'd1, 16'd2, 16'd3, 16'd4};
    a = '{16'd4, 16'd3, 16'd2, 16'd1};
    exp_q.push_back(dot(w, a) + dot(w, a));
    do_start(16'd2, 2'b10, 32'd0);
    start = 1'b1; cfg_k = 16'd7; cfg_ctrl = 2'b01; cfg_acc = 32'd999;
    @(negedge clk);
    start = 1'b0;
    check32("ctrl_hold_feed", 32'(u_ctrl), 32'd2);
    feed_beat(w, a, 0);
    check32("ctrl_hold_wait", 32'(u_ctrl), 32'd2);
    feed_beat(w, a, 0);
    get_result(0, 1'b0);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
